// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps exactly one imem request outstanding and
// buffers the returned word in a one-entry output register toward decode.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    output logic [2:0]      if_funct3,
    output logic [6:0]      if_funct7
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;

    // Misaligned targets are silently aligned; no trap is raised here.
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    assign if_opcode = if_instr[6:0];
    assign if_funct3 = if_instr[14:12];
    assign if_funct7 = if_instr[31:25];

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            // A handshake in this cycle still completes; the held word is simply not re-presented.
            pc       <= redirect_target;
            if_valid <= 1'b0;
            case (state)
                // An accepted request targets the old PC, so its response must be drained.
                S_REQ:           state <= imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state <= imem_resp_valid ? S_REQ : S_DRAIN;
                default:         state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if_instr <= imem_resp_data;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        pc       <= pc + XLEN'(4);
                        state    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
